// File: rtl/display_capture.sv
// Purpose: receive-side mirror of the multiplexed 7-segment driver; rebuilds hex frame + radix points from scanned lines.
// Latency: slot captured SETTLE_CYCLES+1 edges after its strobe appears; completed frame published one edge after the last capture.
// Backpressure: none; free-running observer, frame_valid_o is a one-cycle pulse with no ready handshake.
module display_capture #(
    parameter int NUM_DIGITS    = 8,
    parameter int ACTIVE_LOW    = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_DIGITS-1:0]     digit,
    input  logic [7:0]                segment,
    output logic [4*NUM_DIGITS-1:0]   value_o,
    output logic [NUM_DIGITS-1:0]     point_o,
    output logic                      frame_valid_o,
    output logic                      strobe_err_o,
    output logic                      pattern_err_o
);

    localparam logic [3:0] SETTLE_MAX = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // Active-high views of the raw lines
    logic [NUM_DIGITS-1:0] digit_norm;
    logic [7:0]            seg_norm;

    assign digit_norm = (ACTIVE_LOW != 0) ? ~digit   : digit;
    assign seg_norm   = (ACTIVE_LOW != 0) ? ~segment : segment;

    // Sample stage and one-deep history for the stability compare
    logic [NUM_DIGITS-1:0] samp_digit;
    logic [7:0]            samp_seg;
    logic [NUM_DIGITS-1:0] prev_digit;
    logic [7:0]            prev_seg;

    // FSM and settle counter
    state_t     state;
    state_t     state_nxt;
    logic [3:0] settle_cnt;
    logic [3:0] settle_cnt_nxt;
    logic       capture;

    // Frame assembly
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_pt;
    logic [NUM_DIGITS-1:0]   seen;
    logic [NUM_DIGITS-1:0]   cap_mask;
    logic                    seen_full;

    logic       stable;
    logic       blank;
    logic       onehot;
    logic [4:0] glyph_dec;

    // Map an active-high gfedcba pattern to {illegal, nibble}
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'h3F:   r = {1'b0, 4'h0};
            7'h06:   r = {1'b0, 4'h1};
            7'h5B:   r = {1'b0, 4'h2};
            7'h4F:   r = {1'b0, 4'h3};
            7'h66:   r = {1'b0, 4'h4};
            7'h6D:   r = {1'b0, 4'h5};
            7'h7D:   r = {1'b0, 4'h6};
            7'h07:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h6F:   r = {1'b0, 4'h9};
            7'h77:   r = {1'b0, 4'hA};
            7'h7C:   r = {1'b0, 4'hB};
            7'h39:   r = {1'b0, 4'hC};
            7'h5E:   r = {1'b0, 4'hD};
            7'h79:   r = {1'b0, 4'hE};
            7'h71:   r = {1'b0, 4'hF};
            default: r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    assign stable    = (samp_digit == prev_digit) && (samp_seg == prev_seg);
    assign blank     = (samp_digit == '0);
    assign onehot    = !blank && ((samp_digit & (samp_digit - NUM_DIGITS'(1))) == '0);
    assign glyph_dec = decode_glyph(samp_seg[6:0]);
    assign cap_mask  = (capture && onehot) ? samp_digit : '0;
    assign seen_full = &seen;

    // Register normalised inputs and keep the previous sample
    always_ff @(posedge clock) begin
        if (reset) begin
            samp_digit <= '0;
            samp_seg   <= '0;
            prev_digit <= '0;
            prev_seg   <= '0;
        end else begin
            samp_digit <= digit_norm;
            samp_seg   <= seg_norm;
            prev_digit <= samp_digit;
            prev_seg   <= samp_seg;
        end
    end

    // FSM state and settle counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // Next state: settle on a new strobe, capture once the sample has held long enough
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        capture        = 1'b0;
        case (state)
            IDLE: begin
                if (!blank) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                end
            end
            SETTLE: begin
                if (blank) begin
                    state_nxt      = IDLE;
                    settle_cnt_nxt = '0;
                end else if (!stable) begin
                    settle_cnt_nxt = '0;
                end else if ((settle_cnt + 4'd1) >= SETTLE_MAX) begin
                    // This stable sample is the last one needed: capture now
                    capture        = 1'b1;
                    state_nxt      = HELD;
                    settle_cnt_nxt = SETTLE_MAX;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            HELD: begin
                if (blank) begin
                    state_nxt      = IDLE;
                    settle_cnt_nxt = '0;
                end else if (!stable) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt      = IDLE;
                settle_cnt_nxt = '0;
            end
        endcase
    end

    // Shadow frame: one-hot captures write the addressed nibble and point
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_val <= '0;
            shadow_pt  <= '0;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cap_mask[i]) begin
                    shadow_val[4*i +: 4] <= glyph_dec[3:0];
                    shadow_pt[i]         <= samp_seg[7];
                end
            end
        end
    end

    // Frame publish, seen tracking and sticky errors; a capture on the clear edge joins the new frame
    always_ff @(posedge clock) begin
        if (reset) begin
            seen          <= '0;
            value_o       <= '0;
            point_o       <= '0;
            frame_valid_o <= 1'b0;
            strobe_err_o  <= 1'b0;
            pattern_err_o <= 1'b0;
        end else begin
            seen          <= (seen_full ? '0 : seen) | cap_mask;
            frame_valid_o <= seen_full;
            if (seen_full) begin
                value_o <= shadow_val;
                point_o <= shadow_pt;
            end
            if (capture && !onehot) begin
                strobe_err_o <= 1'b1;
            end
            if (capture && onehot && glyph_dec[4]) begin
                pattern_err_o <= 1'b1;
            end
        end
    end

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receive-side mirror of the multiplexed 7-segment display driver.
- Samples the scanned digit strobes and segment lines, debounces each digit slot, and decodes segment patterns back to hex nibbles and radix points.
- Reassembles a full display frame and publishes it with a one-cycle valid pulse.
- Used in benches and on-chip loopback to check the ADPLL error readout without a human reading the LEDs.

Parameters:
- NUM_DIGITS, 8, number of scanned digit positions.
- ACTIVE_LOW, 1, 1: digit and segment lines are active-low; 0: active-high.
- SETTLE_CYCLES, 2, extra consecutive identical samples required before a slot is captured (1..15).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- digit  in  NUM_DIGITS  digit strobes from display driver; bit i = digit i.
- segment  in  8  segment lines {dp,g,f,e,d,c,b,a}, bit 7 = dp.
- value_o  out  4*NUM_DIGITS  decoded frame; nibble i = digit i.
- point_o  out  NUM_DIGITS  decoded radix points; bit i = digit i.
- frame_valid_o  out  1  one-cycle pulse when value_o/point_o update.
- strobe_err_o  out  1  sticky: more than one digit strobe active in a captured-stable sample.
- pattern_err_o  out  1  sticky: a captured segment pattern is not a legal hex glyph.

Behaviour:
- Sync reset and active-high clock are fixed.
- Reset values: value_o=0, point_o=0, frame_valid_o=0, strobe_err_o=0, pattern_err_o=0. Internal shadow, seen-mask and settle counter are cleared; FSM goes to IDLE.
- Input normalisation: if ACTIVE_LOW, invert digit and segment internally. All logic below uses active-high levels.
- Inputs are registered once (sample stage). Stability compares the current sample with the previous sample.
- FSM states:
  - IDLE: no strobe active (digit==0).
    - Any nonzero digit -> SETTLE, counter=0.
  - SETTLE: counter increments each cycle the sample equals the previous sample.
    - Any change in digit or segment -> counter=0 and stay in SETTLE, or go to IDLE if digit==0.
    - counter==SETTLE_CYCLES -> capture, then go to HELD.
  - HELD: slot already captured; no recapture while the sample is unchanged.
    - digit==0 -> IDLE.
    - Any other change -> SETTLE, counter=0 (a rewrite of the same digit overwrites its shadow entry; no error).
- Capture, one-hot strobe for digit i:
  - shadow nibble i = decoded glyph; shadow point i = dp; seen[i]=1.
- Capture, multi-hot strobe:
  - strobe_err_o set; nothing stored; seen unchanged.
- Glyph decode, active-high gfedcba:
  - 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9, 77=A, 7C=B, 39=C, 5E=D, 79=E, 71=F.
  - Any other pattern stores nibble 0, sets pattern_err_o, and still marks the slot seen.
- Frame completion: on the clock edge after the capture that makes seen all-ones:
  - value_o<=shadow, point_o<=shadow points, frame_valid_o=1 for exactly one cycle.
  - seen is cleared in the same edge.
  - The shadow is retained, so a later partial frame overwrites only the slots it captures.
- Latency: a digit held stable from edge 0 is captured at sample edge SETTLE_CYCLES+1 (counting the input register). If that completes the frame, outputs update one edge later.
- Simultaneous events: a capture into seen on the same edge as the frame clear counts toward the new frame.
- Reset mid-frame: the partial frame is discarded and sticky errors are cleared.
- Widths: counter is 4 bits and saturates at SETTLE_CYCLES. value_o nibble order is fixed LSB = digit 0.

Test Plan:
- Reset, then drive an ACTIVE_LOW scan of 0x1234ABCD with no points, each digit held 6 cycles, SETTLE=2 -> single frame_valid_o pulse; value_o=32'h1234ABCD; point_o=8'h00; errors 0.
- Same scan with every digit held only 2 cycles -> no capture, frame_valid_o never asserts, value_o stays 0.
- Scan 0x000000A5 with dp lit on digits 0 and 4 -> value_o=32'h000000A5; point_o=8'h11.
- Assert digit strobes 0 and 1 together for 10 cycles mid-scan, then continue a normal scan -> strobe_err_o=1 and stays 1; the frame completes only after both slots are rescanned singly.
- Send pattern 7'h00 on digit 3 in an otherwise legal frame -> nibble 3 of value_o = 0; pattern_err_o=1; frame_valid_o pulses.
- Assert reset after 5 of 8 digits have been captured, then run a full scan of 0xFFFFFFFF -> first pulse occurs only after all 8 post-reset captures; value_o=32'hFFFFFFFF; errors 0.
